ultrasonic_ranger: RTL and testbench

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

---
 rtl/ultrasonic_ranger.sv | 144 ++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_ranger.sv
// Periodic ultrasonic range finder: fires a trigger pulse, times the echo,
// and reports floor(echo_us / 58) in centimetres, or 16'hFFFF on timeout.
module ultrasonic_ranger #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_MS  = 60,
    parameter int TIMEOUT_US = 30000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic [15:0] distance_cm,
    output logic        distance_ready,
    output logic        timeout
);

    localparam int CYC_US     = CLK_HZ / 1_000_000;
    localparam int PERIOD_CYC = PERIOD_MS * 1000 * CYC_US;
    localparam int US_MAX     = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
    localparam int PRE_W      = (CYC_US > 1) ? $clog2(CYC_US) : 1;
    localparam int US_W       = $clog2(US_MAX + 1);
    localparam int PER_W      = $clog2(PERIOD_CYC + 1);

    localparam logic [5:0]  CM_US_LAST = 6'd57;
    localparam logic [15:0] CM_SAT     = 16'hFFFE;
    localparam logic [15:0] CM_TIMEOUT = 16'hFFFF;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_TRIG = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MEAS = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CM_SAT) ? v : v + 16'd1;
    endfunction

    logic [2:0]       state, state_nxt;
    logic             echo_p0, echo_p1, echo_p2;
    logic [PRE_W-1:0] pre;
    logic [US_W-1:0]  us_cnt;
    logic [5:0]       sub_us;
    logic [15:0]      cm, cm_nxt;
    logic [PER_W-1:0] per_cnt;
    logic             tick, echo_rise, echo_fall, period_done, timing;
    logic             trig_last, to_last, finish_ok, finish_to;

    assign tick        = (pre == PRE_W'(CYC_US - 1));
    assign echo_rise   = echo_p1 & ~echo_p2;
    assign echo_fall   = ~echo_p1 & echo_p2;
    assign period_done = (per_cnt == PER_W'(PERIOD_CYC - 1));
    assign timing      = (state == S_TRIG) || (state == S_WAIT) || (state == S_MEAS);
    assign trig_last   = tick && (us_cnt == US_W'(TRIG_US - 1));
    assign to_last     = tick && (us_cnt == US_W'(TIMEOUT_US - 1));
    // The microsecond that completes on the falling-edge cycle still counts.
    assign cm_nxt      = (tick && sub_us == CM_US_LAST) ? sat_inc(cm) : cm;

    always_comb begin
        state_nxt = state;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state)
            S_IDLE: if (enable) state_nxt = S_TRIG;
            S_TRIG: if (trig_last) state_nxt = S_WAIT;
            S_WAIT: begin
                if (echo_rise) begin
                    state_nxt = S_MEAS;
                end else if (to_last) begin
                    finish_to = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_MEAS: begin
                if (echo_fall) begin
                    finish_ok = 1'b1;
                    state_nxt = S_HOLD;
                end else if (to_last) begin
                    finish_to = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: if (period_done) state_nxt = enable ? S_TRIG : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            echo_p0        <= 1'b0;
            echo_p1        <= 1'b0;
            echo_p2        <= 1'b0;
            pre            <= '0;
            us_cnt         <= '0;
            sub_us         <= '0;
            cm             <= '0;
            per_cnt        <= '0;
            trig           <= 1'b0;
            distance_cm    <= '0;
            distance_ready <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            // synchronizer stages, then one more flop for edge detection
            echo_p0 <= echo;
            echo_p1 <= echo_p0;
            echo_p2 <= echo_p1;

            state          <= state_nxt;
            trig           <= (state_nxt == S_TRIG);
            distance_ready <= finish_ok | finish_to;
            if (finish_ok) begin
                distance_cm <= cm_nxt;
                timeout     <= 1'b0;
            end else if (finish_to) begin
                distance_cm <= CM_TIMEOUT;
                timeout     <= 1'b1;
            end

            if (state_nxt != state) begin
                pre    <= '0;
                us_cnt <= '0;
                sub_us <= '0;
                cm     <= '0;
            end else if (timing) begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) us_cnt <= us_cnt + 1'b1;
                if (state == S_MEAS) begin
                    if (tick) sub_us <= (sub_us == CM_US_LAST) ? '0 : sub_us + 1'b1;
                    cm <= cm_nxt;
                end
            end

            // period runs from every TRIG entry and parks at its final count
            if (state_nxt == S_TRIG && state != S_TRIG) begin
                per_cnt <= '0;
            end else if (!period_done) begin
                per_cnt <= per_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger, scaled to 2 MHz / 2 ms period /
// 1500 us timeout so whole measurement periods fit in a short run.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

    localparam int CLK_HZ     = 2_000_000;
    localparam int TRIG_US    = 10;
    localparam int PERIOD_MS  = 2;
    localparam int TIMEOUT_US = 1500;
    localparam int CYC_US     = 2;
    localparam int TRIG_CYC   = 20;
    localparam int PERIOD_CYC = 4000;
    localparam int TO_CYC     = 3000;

    logic        clk = 1'b0;
    logic        rst_n, enable, echo;
    logic        trig, distance_ready, timeout;
    logic [15:0] distance_cm;

    ultrasonic_ranger #(
        .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .PERIOD_MS(PERIOD_MS), .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo),
        .trig(trig), .distance_cm(distance_cm),
        .distance_ready(distance_ready), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, last_rise = 0, prev_rise = 0, rise_count = 0, last_width = 0, ready_count = 0;
    logic trig_q = 1'b0;

    int dist_us[5] = '{580, 579, 58, 57, 116};
    int dist_cm[5] = '{10, 9, 1, 0, 2};

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        trig_q <= trig;
        if (trig && !trig_q) begin
            prev_rise  <= last_rise;
            last_rise  <= cyc;
            rise_count <= rise_count + 1;
        end
        if (!trig && trig_q) last_width <= cyc - last_rise;
        if (distance_ready) ready_count <= ready_count + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_trig(input logic level, input int limit, output int n);
        n = 0;
        while (trig !== level && n < limit) begin
            step();
            n++;
        end
        if (trig !== level) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_trig: trig=%b after %0d cycles, required %b", trig, n, level);
        end
    endtask

    task automatic wait_ready(input int limit, output int n);
        n = 0;
        while (distance_ready !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        if (distance_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ready: no distance_ready within %0d cycles", limit);
            n = -1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; echo = 1'b0;
        repeat (3) step();
        vectors += 4;
        if (trig !== 1'b0) begin miscompares++; $display("FAIL rst_trig: got %b, expected 0", trig); end
        if (distance_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b, expected 0", distance_ready); end
        if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b, expected 0", timeout); end
        if (distance_cm !== 16'd0) begin miscompares++; $display("FAIL rst_cm: got %h, expected 0000", distance_cm); end
        enable = 1'b1;
        rst_n  = 1'b1;
        step();
        if (trig !== 1'b1) step();
        vectors++;
        if (trig !== 1'b1) begin miscompares++; $display("FAIL first_trig: got %b by second edge, expected 1", trig); end
    endtask

    task automatic test_timeout();
        int n, r0;
        wait_trig(1'b0, 100, n);
        vectors++;
        if (last_width !== TRIG_CYC) begin miscompares++; $display("FAIL trig_width: got %0d, expected %0d", last_width, TRIG_CYC); end
        r0 = ready_count;
        wait_ready(TO_CYC + 50, n);
        vectors += 3;
        if (n !== TO_CYC) begin miscompares++; $display("FAIL to_latency: got %0d, expected %0d", n, TO_CYC); end
        if (distance_cm !== 16'hFFFF) begin miscompares++; $display("FAIL to_cm: got %h, expected ffff", distance_cm); end
        if (timeout !== 1'b1) begin miscompares++; $display("FAIL to_flag: got %b, expected 1", timeout); end
        step();
        vectors += 2;
        if (distance_ready !== 1'b0) begin miscompares++; $display("FAIL to_pulse: got %b, expected 0", distance_ready); end
        if (distance_cm !== 16'hFFFF) begin miscompares++; $display("FAIL to_hold: got %h, expected ffff", distance_cm); end
        wait_trig(1'b1, PERIOD_CYC, n);
        vectors += 2;
        if (last_rise - prev_rise !== PERIOD_CYC) begin miscompares++; $display("FAIL to_period: got %0d, expected %0d", last_rise - prev_rise, PERIOD_CYC); end
        if (ready_count - r0 !== 1) begin miscompares++; $display("FAIL to_pulses: got %0d, expected 1", ready_count - r0); end
    endtask

    task automatic measure(input int us, input int exp_cm, input bit chk_period);
        int n, r0;
        wait_trig(1'b0, 100, n);
        r0 = ready_count;
        repeat (3) step();
        echo = 1'b1;
        repeat (us * CYC_US) step();
        echo = 1'b0;
        wait_ready(20, n);
        vectors += 3;
        if (n !== 3) begin miscompares++; $display("FAIL ready_lat_%0dus: got %0d, expected 3", us, n); end
        if (distance_cm !== 16'(exp_cm)) begin miscompares++; $display("FAIL cm_%0dus: got %0d, expected %0d", us, distance_cm, exp_cm); end
        if (timeout !== 1'b0) begin miscompares++; $display("FAIL flag_%0dus: got %b, expected 0", us, timeout); end
        step();
        vectors++;
        if (distance_ready !== 1'b0) begin miscompares++; $display("FAIL pulse_%0dus: got %b, expected 0", us, distance_ready); end
        wait_trig(1'b1, PERIOD_CYC, n);
        vectors++;
        if (ready_count - r0 !== 1) begin miscompares++; $display("FAIL pulses_%0dus: got %0d, expected 1", us, ready_count - r0); end
        if (chk_period) begin
            vectors++;
            if (last_rise - prev_rise !== PERIOD_CYC) begin miscompares++; $display("FAIL spacing_%0dus: got %0d, expected %0d", us, last_rise - prev_rise, PERIOD_CYC); end
        end
    endtask

    task automatic test_distance();
        for (int i = 0; i < 5; i++) measure(dist_us[i], dist_cm[i], 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) measure(1160, 20, 1'b1);
    endtask

    task automatic test_echo_stuck_high();
        int n, r0, r1;
        wait_trig(1'b0, 100, n);
        r0 = ready_count;
        wait_ready(TO_CYC + 50, n);
        step();
        echo = 1'b1;
        wait_trig(1'b1, PERIOD_CYC, n);
        vectors++;
        if (ready_count - r0 !== 1) begin miscompares++; $display("FAIL hold_echo_pulses: got %0d, expected 1", ready_count - r0); end
        wait_trig(1'b0, 100, n);
        r1 = ready_count;
        wait_ready(TO_CYC + 50, n);
        vectors += 3;
        if (n !== TO_CYC) begin miscompares++; $display("FAIL stuck_latency: got %0d, expected %0d", n, TO_CYC); end
        if (distance_cm !== 16'hFFFF) begin miscompares++; $display("FAIL stuck_cm: got %h, expected ffff", distance_cm); end
        if (timeout !== 1'b1) begin miscompares++; $display("FAIL stuck_flag: got %b, expected 1", timeout); end
        repeat (100) step();
        echo = 1'b0;
        wait_trig(1'b1, PERIOD_CYC, n);
        vectors++;
        if (ready_count - r1 !== 1) begin miscompares++; $display("FAIL stuck_pulses: got %0d, expected 1", ready_count - r1); end
    endtask

    task automatic test_enable_drop();
        int n, r0, rc;
        wait_trig(1'b0, 100, n);
        r0 = ready_count;
        repeat (3) step();
        echo = 1'b1;
        repeat (400) step();
        enable = 1'b0;
        repeat (760) step();
        echo = 1'b0;
        wait_ready(20, n);
        vectors += 2;
        if (distance_cm !== 16'd10) begin miscompares++; $display("FAIL endrop_cm: got %0d, expected 10", distance_cm); end
        if (timeout !== 1'b0) begin miscompares++; $display("FAIL endrop_flag: got %b, expected 0", timeout); end
        rc = rise_count;
        repeat (PERIOD_CYC + 500) step();
        vectors += 4;
        if (rise_count !== rc) begin miscompares++; $display("FAIL endrop_idle: got %0d trig rises, expected %0d", rise_count, rc); end
        if (trig !== 1'b0) begin miscompares++; $display("FAIL endrop_trig: got %b, expected 0", trig); end
        if (ready_count - r0 !== 1) begin miscompares++; $display("FAIL endrop_pulses: got %0d, expected 1", ready_count - r0); end
        if (distance_cm !== 16'd10) begin miscompares++; $display("FAIL endrop_hold: got %0d, expected 10", distance_cm); end
    endtask

    task automatic test_reset_mid();
        int n, r0;
        enable = 1'b1;
        wait_trig(1'b1, 4, n);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        vectors += 2;
        if (trig !== 1'b0) begin miscompares++; $display("FAIL rst_trig_mid: got %b, expected 0", trig); end
        if (distance_cm !== 16'd0) begin miscompares++; $display("FAIL rst_cm_mid: got %0d, expected 0", distance_cm); end
        repeat (3) step();
        rst_n = 1'b1;
        wait_trig(1'b1, 2, n);
        vectors++;
        if (n < 1 || n > 2) begin miscompares++; $display("FAIL rst_restart: got %0d edges, expected 1 or 2", n); end
        wait_trig(1'b0, 100, n);
        r0 = ready_count;
        repeat (3) step();
        echo = 1'b1;
        repeat (200) step();
        rst_n = 1'b0;
        #1;
        vectors += 2;
        if (distance_ready !== 1'b0) begin miscompares++; $display("FAIL rst_meas_ready: got %b, expected 0", distance_ready); end
        if (timeout !== 1'b0) begin miscompares++; $display("FAIL rst_meas_flag: got %b, expected 0", timeout); end
        echo   = 1'b0;
        enable = 1'b0;
        repeat (5) step();
        rst_n = 1'b1;
        repeat (300) step();
        vectors += 2;
        if (ready_count !== r0) begin miscompares++; $display("FAIL rst_meas_pulses: got %0d, expected 0", ready_count - r0); end
        if (trig !== 1'b0) begin miscompares++; $display("FAIL rst_meas_trig: got %b, expected 0", trig); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_distance();
        test_back_to_back();
        test_echo_stuck_high();
        test_enable_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
